lsu_align: RTL
==============

Name: lsu_align

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Accepts one load/store request at a time from the memory stage of the datapath and drives the data memory's addr/wdata/wmask/we port.
- For loads, extracts bytes from the returned word and sign- or zero-extends them.
- Accesses that cross a 32-bit word boundary are split into two sequential word accesses, since the data memory only handles bytes within one word.

Parameters:
- XLEN, 32, data/address width (from constants.vh); the block supports XLEN=32 only.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data (0 for stores/faults)
- resp_fault  out  1  request rejected, no memory effect
- dmem_addr  out  XLEN  to data memory
- dmem_wdata  out  XLEN  to data memory, right-aligned
- dmem_wmask  out  XLEN  to data memory, right-aligned byte mask
- dmem_we  out  1  to data memory
- dmem_rdata  in  XLEN  from data memory, combinational word at dmem_addr>>2

Interface decision: one clock (clk); reset is synchronous and active-low (rst_n).

Behaviour:
- Reset values:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=0, dmem_we=0.
  - req_ready=0 while rst_n=0.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/funct3/addr/wdata; next state is ACC0.
  - Illegal funct3 (load 3,6,7; store ≥3) latches fault and goes straight to DONE.
- Derived values:
  - off=addr[1:0].
  - size=1/2/4 from funct3[1:0].
  - smask=byte mask of size.
  - cross = off+size > 4.
- ACC0:
  - dmem_addr=addr, dmem_wdata=wdata.
  - dmem_wmask = smask & (all-ones >> 8*off).
  - dmem_we=we.
  - Loads capture lo = dmem_rdata >> 8*off.
  - Next state is ACC1 if cross, else DONE.
- ACC1:
  - dmem_addr = {addr[31:2]+1, 2'b00}; wraps modulo 2^32 (addr 0xFFFFFFFE word access reaches word 0).
  - dmem_wdata = wdata >> 8*(4-off).
  - dmem_wmask = smask >> 8*(4-off).
  - dmem_we=we.
  - Loads capture hi = dmem_rdata << 8*(4-off).
  - Next state is DONE.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = extend((lo|hi) & smask): sign-extend for LB/LH, zero-extend for LBU/LHU/LW.
  - resp_fault is as latched.
  - Next state is IDLE.
- dmem_we is 0 in IDLE and DONE, and 0 whenever rst_n=0, so that no write occurs on a reset edge.
- Latency from the accept edge:
  - non-crossing: resp_valid 2 cycles later.
  - crossing: 3 cycles later.
  - fault: 1 cycle later.
- req_valid while req_ready=0 is ignored; the requester holds it.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE.
- Reset mid-operation:
  - Returns to IDLE and discards the latched request.
  - A half-completed split store leaves the ACC0 word written and the ACC1 word untouched.

Optional Feature:
- Macro LSU_MISALIGNED_TRAP_EN.
- When defined:
  - Any access with addr not naturally aligned to its size (LH/SH with off odd, LW/SW with off≠0) faults: IDLE goes to DONE, resp_fault=1, no dmem_we.
  - ACC1 logic is not built.
- When undefined: misaligned accesses complete as described in Behaviour, with crossing accesses split.

Test Plan:
Memory is preloaded with word0=0x11223344 and word1=0x55667788 (little-endian).
- LW addr 0x0 accepted at cycle T -> resp_valid at T+2, resp_rdata=0x11223344, resp_fault=0, dmem_we never high.
- LB addr 0x4 -> 0xFFFFFF88; LBU addr 0x4 -> 0x00000088; LH addr 0x2 -> 0x00001122; each at T+2.
- LH addr 0x3 -> dmem_addr 0x3 then 0x4; resp at T+3 with 0xFFFF8811.
- SW 0xAABBCCDD addr 0x2 -> two dmem_we pulses; word0=0xCCDD3344, word1=0x5566AABB. Repeat with LSU_MISALIGNED_TRAP_EN defined -> resp_fault=1 at T+1, both words unchanged.
- Load funct3=3 addr 0x0 -> resp_valid at T+1, resp_fault=1, resp_rdata=0, no dmem_we.
- SW 0xAABBCCDD addr 0x2 with rst_n low during ACC1 -> word0=0xCCDD3344, word1 stays 0x55667788. No resp_valid; req_ready=0 during reset and 1 one cycle after release.

Source files
------------

// File: rtl/lsu_align_if.sv
// Request/response and data-memory bus of the load/store aligner.
// The slave modport is the aligner's view; master is the requester/memory side.
interface lsu_align_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_wmask;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           dmem_addr, dmem_wdata, dmem_wmask, dmem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           dmem_addr, dmem_wdata, dmem_wmask, dmem_we
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store aligner in front of a word-wide data memory; word-crossing accesses are split in two.
// Define LSU_MISALIGNED_TRAP_EN to fault misaligned accesses instead of splitting them.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_align_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic            r_fault;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_hi;

  logic            w_accept;
  logic            w_fault_in;
  logic [1:0]      w_off;
  logic [4:0]      w_sh_lo;
  logic [5:0]      w_sh_hi;
  logic [2:0]      w_size;
  logic [2:0]      w_end;
  logic            w_cross;
  logic [XLEN-1:0] w_smask;
  logic [XLEN-3:0] w_next_word;

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'd1:    size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      default: size_mask = {XLEN{1'b1}};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    extend = {{(XLEN-8){d[7]}}, d[7:0]};
      3'd1:    extend = {{(XLEN-16){d[15]}}, d[15:0]};
      3'd4:    extend = {{(XLEN-8){1'b0}}, d[7:0]};
      3'd5:    extend = {{(XLEN-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  function automatic logic illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGNED_TRAP_EN
    bad = bad | (f3[1:0] == 2'd1 && off[0]) | (f3[1:0] == 2'd2 && off != 2'd0);
`else
    bad = bad | (off == 2'd0 && 1'b0);
`endif
    illegal = bad;
  endfunction

  assign w_accept    = bus.req_valid & bus.req_ready;
  assign w_fault_in  = illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign w_off       = r_addr[1:0];
  assign w_sh_lo     = {w_off, 3'b000};
  assign w_sh_hi     = 6'd32 - {1'b0, w_off, 3'b000};
  assign w_size      = (r_funct3[1:0] == 2'd0) ? 3'd1 : (r_funct3[1:0] == 2'd1) ? 3'd2 : 3'd4;
  assign w_end       = {1'b0, w_off} + w_size;
  assign w_cross     = (w_end > 3'd4);
  assign w_smask     = size_mask(r_funct3[1:0]);
  assign w_next_word = r_addr[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1};

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_fault <= w_fault_in;
    end
  end

  // Request and load-data capture
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= bus.req_we;
      r_funct3 <= bus.req_funct3;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_hi     <= '0;
    end
    if (r_state == ACC0) r_lo <= bus.dmem_rdata >> w_sh_lo;
    if (r_state == ACC1) r_hi <= bus.dmem_rdata << w_sh_hi;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_fault_in ? DONE : ACC0;
`ifdef LSU_MISALIGNED_TRAP_EN
      ACC0: w_next = DONE;
`else
      ACC0: w_next = w_cross ? ACC1 : DONE;
      ACC1: w_next = DONE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = rst_n && (r_state == IDLE);
    bus.resp_valid = rst_n && (r_state == DONE);
    bus.resp_fault = (r_state == DONE) && r_fault;
    bus.resp_rdata = '0;
    bus.dmem_addr  = r_addr;
    bus.dmem_wdata = r_wdata;
    bus.dmem_wmask = '0;
    bus.dmem_we    = 1'b0;
    case (r_state)
      ACC0: begin
        bus.dmem_wmask = w_smask & ({XLEN{1'b1}} >> w_sh_lo);
        bus.dmem_we    = r_we & rst_n;
      end
`ifndef LSU_MISALIGNED_TRAP_EN
      ACC1: begin
        bus.dmem_addr  = {w_next_word, 2'b00};
        bus.dmem_wdata = r_wdata >> w_sh_hi;
        bus.dmem_wmask = w_smask >> w_sh_hi;
        bus.dmem_we    = r_we & rst_n;
      end
`endif
      DONE: if (!r_fault && !r_we) bus.resp_rdata = extend((r_lo | r_hi) & w_smask, r_funct3);
      default: ;
    endcase
  end
endmodule
